dma_ci_frontend: RTL
====================

Name: dma_ci_frontend

Overview:
- Custom-instruction front end that sits directly upstream of the bus-master DMA engine.
- Decodes CPU custom instructions into the DMA configuration registers: bus address, memory address, block size, burst size and control.
- Gives the CPU single-word access to the 512x32 scratch SRAM through a dedicated port.
- Issues a one-cycle start pulse to the DMA and reports its busy/error status back to the CPU.

Parameters:
customId, 8'h00, custom-instruction number this block answers to
MEM_LATENCY, 1, SRAM read latency in cycles (supported values 1 or 2)

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  CI request strobe, 1 cycle
ciN  input  8  CI number
valueA  input  32  [12:10] function select, [9] write enable, [8:0] SRAM word address
valueB  input  32  write data
done  output  1  CI completion, 1-cycle pulse
result  output  32  CI read data; 0 whenever done=0
memAddr  output  9  SRAM word address
memWe  output  1  SRAM write strobe
memWdata  output  32  SRAM write data
memRdata  input  32  SRAM read data, valid MEM_LATENCY cycles after address
bAddrOut  output  32  DMA bus start address
mAddrOut  output  9  DMA SRAM start address
blockSOut  output  10  DMA block size in words
burstSOut  output  8  DMA burst size (words-1)
controlOut  output  2  DMA control: 01 = bus->SRAM, 10 = SRAM->bus, 00 = stop
dmaStart  output  1  1-cycle pulse; DMA latches controlOut
dmaStatusIn  input  4  DMA FSM state code: 0 idle, 7 error, others busy

Behaviour:
- Reset state:
  - done=0, result=0, memWe=0, memAddr=0, memWdata=0, dmaStart=0.
  - All config registers 0; controlOut=2'b00; busy=0; errSticky=0; FSM=IDLE.
- Acceptance: a CI is accepted only when start=1 and ciN==customId. A start with any other ciN produces no response and no state change.
- Function codes (valueA[12:10]):
  - 0 = SRAM access.
  - 1 = bAddr; 2 = mAddr (valueB[8:0]); 3 = blockS (valueB[9:0]); 4 = burstS (valueB[7:0]); 5 = control/status.
  - 6-7 = reserved: done in 1 cycle, result=0, no side effects.
- Register functions 1-4:
  - Write (valueA[9]=1) updates the register; read returns it zero-extended.
  - done asserts combinationally in the same cycle as start (0-cycle latency).
- SRAM write: memWe=1, memAddr=valueA[8:0], memWdata=valueB in the start cycle; done in the same cycle.
- SRAM read uses an FSM with states IDLE, RD_WAIT, RD_DONE:
  - IDLE -> RD_WAIT on an accepted read; memAddr is driven in the start cycle.
  - RD_WAIT counts MEM_LATENCY-1 extra cycles, then goes to RD_DONE.
  - RD_DONE: done=1, result=memRdata, then back to IDLE.
  - Total latency start->done is MEM_LATENCY+1 cycles.
- Back-to-back CIs: start asserted while the FSM is not IDLE is ignored. The CPU never does this; the bench checks that it is ignored.
- Control write (function 5, valueA[9]=1):
  - If busy=0 and valueB[1:0] is 01 or 10: controlOut<=valueB[1:0], dmaStart=1 for exactly the next cycle, busy<=1, errSticky<=0.
  - valueB[1:0]=00 or 11: controlOut<=00, no dmaStart.
  - done in the same cycle in all cases.
- Busy lockout: while busy=1, writes to functions 1-5 are dropped. done still pulses, so the CPU never stalls.
- Status read (function 5, valueA[9]=0): result = {26'd0, errSticky, busy, dmaStatusIn}.
- Busy tracking:
  - busy clears on the first cycle dmaStatusIn==0 after it was nonzero; the DMA returns to idle.
  - A "seenActive" flag set on nonzero status prevents a false clear during the dmaStart cycle.
  - On clear, controlOut<=00.
- Error handling: dmaStatusIn==7 sets errSticky. busy clears when status returns to 0 as usual.
- SRAM access while busy is allowed; SRAM port arbitration is outside this block.
- Reset mid-operation: a pending read is abandoned, no done is issued, and all registers return to reset values.

Test Plan:
1. Write bAddr=0x0000_1000, mAddr=0x005, blockS=20, burstS=7, then read each back -> done in the same cycle every time; results 0x1000, 5, 20, 7.
2. SRAM write valueA={fn0,we=1,addr=0x1FF}, valueB=0xDEADBEEF, then a read of the same address with MEM_LATENCY=1 -> memWe pulse at addr 0x1FF; read done exactly 2 cycles after start with result 0xDEADBEEF.
3. Control write 01 -> controlOut=01, dmaStart high 1 cycle. Stimulus dmaStatusIn 0->1->2->3->4->0 -> status reads busy=1 until status returns to 0, then busy=0 and controlOut=00.
4. While busy, write blockS=99 and control=10 -> done pulses, blockSOut remains 20, no dmaStart.
5. DMA reports status 7 then 0 -> status read returns 0x20 (errSticky=1, busy=0); the next valid control write clears errSticky.
6. start with ciN!=customId -> no done, no register or SRAM change. Assert reset during RD_WAIT -> no done, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/dma_ci_frontend.sv
// Custom-instruction front end for the bus-master DMA: config register decode,
// single-word scratch SRAM access and the DMA start/status handshake.
//
// state      | meaning
// ST_IDLE    | accepting CIs; register, control and SRAM-write CIs complete here
// ST_RD_WAIT | SRAM read address issued, waiting out the remaining read latency
// ST_RD_DONE | memRdata valid; done pulses with the read word
module dma_ci_frontend #(
  parameter logic [7:0] customId    = 8'h00,
  parameter int         MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic [8:0]  memAddr,
  output logic        memWe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  output logic [31:0] bAddrOut,
  output logic [8:0]  mAddrOut,
  output logic [9:0]  blockSOut,
  output logic [7:0]  burstSOut,
  output logic [1:0]  controlOut,
  output logic        dmaStart,
  input  logic [3:0]  dmaStatusIn
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_RD_DONE} state_e;

  localparam logic [2:0] FN_SRAM   = 3'd0;
  localparam logic [2:0] FN_BADDR  = 3'd1;
  localparam logic [2:0] FN_MADDR  = 3'd2;
  localparam logic [2:0] FN_BLOCKS = 3'd3;
  localparam logic [2:0] FN_BURSTS = 3'd4;
  localparam logic [2:0] FN_CTRL   = 3'd5;
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] b_addr_q, b_addr_d;
  logic [8:0]  m_addr_q, m_addr_d;
  logic [9:0]  block_s_q, block_s_d;
  logic [7:0]  burst_s_q, burst_s_d;
  logic [1:0]  control_q, control_d;
  logic        dma_start_q, dma_start_d;
  logic        busy_q, busy_d;
  logic        seen_active_q, seen_active_d;
  logic        err_sticky_q, err_sticky_d;
  logic [8:0]  mem_addr_q, mem_addr_d;

  logic [2:0]  fn;
  logic        wr_en;
  logic        accept;
  logic        cfg_wr;
  logic        ctrl_go;
  logic        unused_ok;

  assign fn        = valueA[12:10];
  assign wr_en     = valueA[9];
  assign accept    = start && (ciN == customId) && (state_q == ST_IDLE);
  assign cfg_wr    = accept && wr_en && !busy_q;
  assign ctrl_go   = (valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10);
  assign unused_ok = ^valueA[31:13];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (fn == FN_SRAM) && !wr_en) begin
          state_d    = ST_RD_WAIT;
          wait_cnt_d = WAIT_INIT;
        end
      end
      ST_RD_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = ST_RD_DONE;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end
      ST_RD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      b_addr_q      <= '0;
      m_addr_q      <= '0;
      block_s_q     <= '0;
      burst_s_q     <= '0;
      control_q     <= '0;
      dma_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      seen_active_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      b_addr_q      <= b_addr_d;
      m_addr_q      <= m_addr_d;
      block_s_q     <= block_s_d;
      burst_s_q     <= burst_s_d;
      control_q     <= control_d;
      dma_start_q   <= dma_start_d;
      busy_q        <= busy_d;
      seen_active_q <= seen_active_d;
      err_sticky_q  <= err_sticky_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  always_comb begin
    b_addr_d      = b_addr_q;
    m_addr_d      = m_addr_q;
    block_s_d     = block_s_q;
    burst_s_d     = burst_s_q;
    control_d     = control_q;
    dma_start_d   = 1'b0;
    busy_d        = busy_q;
    seen_active_d = seen_active_q;
    err_sticky_d  = err_sticky_q;
    mem_addr_d    = (accept && (fn == FN_SRAM)) ? valueA[8:0] : mem_addr_q;

    if (dmaStatusIn == 4'd7) err_sticky_d = 1'b1;

    // Status is still 0 in the dmaStart cycle, so only clear busy once the DMA was seen active.
    if (busy_q) begin
      if (dmaStatusIn != 4'd0) begin
        seen_active_d = 1'b1;
      end else if (seen_active_q) begin
        busy_d        = 1'b0;
        seen_active_d = 1'b0;
        control_d     = 2'b00;
      end
    end

    if (cfg_wr) begin
      case (fn)
        FN_BADDR:  b_addr_d  = valueB;
        FN_MADDR:  m_addr_d  = valueB[8:0];
        FN_BLOCKS: block_s_d = valueB[9:0];
        FN_BURSTS: burst_s_d = valueB[7:0];
        FN_CTRL: begin
          if (ctrl_go) begin
            control_d     = valueB[1:0];
            dma_start_d   = 1'b1;
            busy_d        = 1'b1;
            seen_active_d = 1'b0;
            err_sticky_d  = 1'b0;
          end else begin
            control_d     = 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Writes return 0 as their result; only reads carry data.
  always_comb begin
    done     = 1'b0;
    result   = '0;
    memWe    = 1'b0;
    memWdata = '0;
    memAddr  = mem_addr_q;
    if (state_q == ST_RD_DONE) begin
      done   = 1'b1;
      result = memRdata;
    end else if (accept) begin
      done = (fn != FN_SRAM) || wr_en;
      case (fn)
        FN_SRAM: begin
          memAddr = valueA[8:0];
          if (wr_en) begin
            memWe    = 1'b1;
            memWdata = valueB;
          end
        end
        FN_BADDR:  if (!wr_en) result = b_addr_q;
        FN_MADDR:  if (!wr_en) result = {23'd0, m_addr_q};
        FN_BLOCKS: if (!wr_en) result = {22'd0, block_s_q};
        FN_BURSTS: if (!wr_en) result = {24'd0, burst_s_q};
        FN_CTRL:   if (!wr_en) result = {26'd0, err_sticky_q, busy_q, dmaStatusIn};
        default: ;
      endcase
    end
  end

  assign bAddrOut   = b_addr_q;
  assign mAddrOut   = m_addr_q;
  assign blockSOut  = block_s_q;
  assign burstSOut  = burst_s_q;
  assign controlOut = control_q;
  assign dmaStart   = dma_start_q;

endmodule
